// File: rtl/cla_sequencer_pkg.sv
// Shared definitions for the carry_look_ahead sequencer: FSM encoding and counter sizing.
package cla_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_B = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Settle counter covers SETTLE_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/cla_sequencer_carry_look_ahead.sv
// Combinational carry-lookahead adder: sum and carry-out of two WIDTH-bit operands, no carry-in.
module carry_look_ahead #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   cy;
    logic             term;

    // Each carry is the OR of every lower generate propagated through the bits above it.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        cy   = '0;
        term = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                cy[i+1] = cy[i+1] | term;
            end
        end
        s = p ^ cy[WIDTH-1:0];
        c = cy[WIDTH];
    end

endmodule

// File: rtl/cla_sequencer.sv
// Multi-cycle controller: captures A then B over one bus, holds them on the shared
// carry_look_ahead for a settle window, then registers the sum/carry and pulses out_valid.
module cla_sequencer
    import cla_sequencer_pkg::*;
#(
    parameter int WIDTH         = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             acc_mode,
    output logic             busy,
    output logic             phase_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] s;
    logic             c;

    carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
        .a (a_reg),
        .b (b_reg),
        .s (s),
        .c (c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            counter   <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= acc_mode ? out_sum : in_data;
                        state <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        b_reg   <= in_data;
                        counter <= CNT_W'(SETTLE_CYCLES - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        out_sum   <= s;
                        out_carry <= c;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state == S_WAIT);
    assign phase_b = (state == S_LOAD_B);

endmodule

// File: tb/tb_cla_sequencer.sv
// Self-checking bench for cla_sequencer: table vectors, hand-written corner sequences and
// randomized operations against an arithmetic reference model, on SETTLE_CYCLES=2/1/15 builds.
module tb_cla_sequencer;

    localparam int W = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [2:0]        iv = '0;
    logic [2:0]        ac = '0;
    logic [2:0][W-1:0] id = '0;
    logic [2:0]        bz, pb, ov, oc;
    logic [2:0][W-1:0] os;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_sequencer #(.WIDTH(W), .SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .acc_mode(ac[0]),
        .busy(bz[0]), .phase_b(pb[0]), .out_valid(ov[0]), .out_sum(os[0]), .out_carry(oc[0])
    );
    cla_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .acc_mode(ac[1]),
        .busy(bz[1]), .phase_b(pb[1]), .out_valid(ov[1]), .out_sum(os[1]), .out_carry(oc[1])
    );
    cla_sequencer #(.WIDTH(W), .SETTLE_CYCLES(15)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id[2]), .acc_mode(ac[2]),
        .busy(bz[2]), .phase_b(pb[2]), .out_valid(ov[2]), .out_sum(os[2]), .out_carry(oc[2])
    );

    typedef struct {
        logic [W-1:0] a;
        logic         acc;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present word as operand A for exactly one edge (caller ensures the DUT is idle).
    task automatic send_a(input int k, input logic [W-1:0] a, input logic acc);
        iv[k] = 1'b1;
        id[k] = a;
        ac[k] = acc;
        tick();
        iv[k] = 1'b0;
        ac[k] = 1'b0;
    endtask

    // Present B, then wait (bounded) for out_valid. lat counts edges from the B-accept
    // edge to the edge that captures out_valid=1; returns in the out_valid cycle.
    task automatic finish_b(input int k, input logic [W-1:0] b, input logic drop,
                            output logic [W-1:0] s, output logic c,
                            output int lat, output int bcnt);
        bit done;
        iv[k] = 1'b1;
        id[k] = b;
        tick();
        iv[k] = 1'b0;
        lat = -1; bcnt = 0; s = '0; c = 1'b0; done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (bz[k]) bcnt++;
            if (ov[k]) begin
                lat = n + 1; s = os[k]; c = oc[k]; done = 1;
            end else begin
                iv[k] = (drop && n == 0);
                id[k] = 7'h33;
                tick();
                iv[k] = 1'b0;
            end
        end
    endtask

    vec_t vecs[6];
    logic [W-1:0] mdl_sum;

    initial begin
        logic [W-1:0] s, ra, rb;
        logic         c, racc, rdrop;
        int           lat, bcnt, gap, seen;
        logic [W:0]   exp;

        vecs[0] = '{a: 7'h25, acc: 1'b0, b: 7'h1A, exp_sum: 7'h3F, exp_carry: 1'b0};
        vecs[1] = '{a: 7'h7F, acc: 1'b0, b: 7'h01, exp_sum: 7'h00, exp_carry: 1'b1};
        vecs[2] = '{a: 7'h7F, acc: 1'b0, b: 7'h7F, exp_sum: 7'h7E, exp_carry: 1'b1};
        vecs[3] = '{a: 7'h10, acc: 1'b0, b: 7'h05, exp_sum: 7'h15, exp_carry: 1'b0};
        vecs[4] = '{a: 7'h55, acc: 1'b1, b: 7'h03, exp_sum: 7'h18, exp_carry: 1'b0};
        vecs[5] = '{a: 7'h00, acc: 1'b0, b: 7'h00, exp_sum: 7'h00, exp_carry: 1'b0};

        tick(); tick();
        rst = 1'b0;
        check("reset out_sum", int'(os[0]), 0);
        check("reset out_carry", int'(oc[0]), 0);
        check("reset out_valid", int'(ov[0]), 0);
        check("reset busy", int'(bz[0]), 0);
        check("reset phase_b", int'(pb[0]), 0);

        foreach (vecs[i]) begin
            send_a(0, vecs[i].a, vecs[i].acc);
            check($sformatf("vec%0d phase_b after A", i), int'(pb[0]), 1);
            finish_b(0, vecs[i].b, 1'b0, s, c, lat, bcnt);
            check($sformatf("vec%0d sum", i), int'(s), int'(vecs[i].exp_sum));
            check($sformatf("vec%0d carry", i), int'(c), int'(vecs[i].exp_carry));
            check($sformatf("vec%0d latency", i), lat, 3);
            check($sformatf("vec%0d busy cycles", i), bcnt, 2);
            tick();
            check($sformatf("vec%0d out_valid one cycle", i), int'(ov[0]), 0);
            check($sformatf("vec%0d sum held", i), int'(os[0]), int'(vecs[i].exp_sum));
        end

        // Drop during S_WAIT, then back-to-back accumulate taken in the out_valid cycle.
        send_a(0, 7'h11, 1'b0);
        finish_b(0, 7'h22, 1'b1, s, c, lat, bcnt);
        check("drop sum", int'(s), 'h33);
        check("drop latency", lat, 3);
        check("drop state idle", int'(pb[0]) + int'(bz[0]), 0);
        send_a(0, 7'h7F, 1'b1);
        check("b2b accepted as A", int'(pb[0]), 1);
        finish_b(0, 7'h01, 1'b0, s, c, lat, bcnt);
        check("b2b acc sum", int'(s), 'h34);
        check("b2b acc carry", int'(c), 0);
        tick();

        // Reset while in S_WAIT discards the operation.
        send_a(0, 7'h40, 1'b0);
        iv[0] = 1'b1; id[0] = 7'h41;
        tick();
        iv[0] = 1'b0;
        check("pre-reset busy", int'(bz[0]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 5; n++) begin
            if (ov[0]) seen++;
            tick();
        end
        check("reset no out_valid", seen, 0);
        check("reset mid-op sum", int'(os[0]), 0);
        check("reset mid-op busy", int'(bz[0]), 0);
        check("reset mid-op phase_b", int'(pb[0]), 0);
        send_a(0, 7'h02, 1'b0);
        finish_b(0, 7'h03, 1'b0, s, c, lat, bcnt);
        check("post-reset sum", int'(s), 5);
        mdl_sum = 7'h05;

        // Randomized operations against an arithmetic model.
        for (int t = 0; t < 60; t++) begin
            racc  = 1'($urandom_range(0, 1));
            rdrop = 1'($urandom_range(0, 1));
            ra    = 7'($urandom);
            rb    = 7'($urandom);
            gap   = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            exp = {1'b0, (racc ? mdl_sum : ra)} + {1'b0, rb};
            send_a(0, ra, racc);
            finish_b(0, rb, rdrop, s, c, lat, bcnt);
            check($sformatf("rand%0d result", t), int'({c, s}), int'(exp));
            check($sformatf("rand%0d latency", t), lat, 3);
            mdl_sum = exp[W-1:0];
        end
        tick();

        // Settle-window extremes.
        send_a(1, 7'h3C, 1'b0);
        finish_b(1, 7'h50, 1'b0, s, c, lat, bcnt);
        check("sc1 latency", lat, 2);
        check("sc1 busy cycles", bcnt, 1);
        check("sc1 result", int'({c, s}), 'h8C);
        send_a(2, 7'h7E, 1'b0);
        finish_b(2, 7'h03, 1'b0, s, c, lat, bcnt);
        check("sc15 latency", lat, 16);
        check("sc15 busy cycles", bcnt, 15);
        check("sc15 result", int'({c, s}), 'h81);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_sequencer.md
Name: cla_sequencer

Overview:
- Multi-cycle controller that sequences the shared carry_look_ahead adder datapath over a narrow operand bus.
- Captures operand A, then operand B, from one WIDTH-bit input port on successive handshakes.
- Holds both operands stable for a programmable settle window, then registers the sum and carry-out and pulses a result-valid strobe.
- Sits between the pin-level top wrapper and the carry_look_ahead instance; supports an accumulate mode where the previous sum becomes operand A.

Parameters:
- WIDTH, 7, operand/sum width in bits; must match the carry_look_ahead instance.
- SETTLE_CYCLES, 2, cycles the operands are held on the adder before the result is sampled; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand strobe; the word is accepted on any edge where in_valid=1 and busy=0.
- in_data  input  WIDTH  operand word.
- acc_mode  input  1  sampled with the A-phase accept; when 1, operand A comes from the stored sum.
- busy  output  1  high while in S_WAIT; in_valid is ignored while high.
- phase_b  output  1  high in S_LOAD_B, meaning the next accept is operand B.
- out_valid  output  1  one-cycle pulse when out_sum/out_carry update.
- out_sum  output  WIDTH  registered sum, held until the next result.
- out_carry  output  1  registered carry-out, held until the next result.

Behaviour:
- Reset (rst=1 at an edge):
  - state=S_IDLE; A, B, counter, out_sum, out_carry, out_valid all cleared to 0.
  - Takes priority over every other event.
  - An operation in flight is discarded and produces no out_valid.
- States:
  - S_IDLE, S_LOAD_B and S_WAIT are encoded in 2 bits; encoding 3 is unreachable and recovers to S_IDLE.
- S_IDLE:
  - busy=0, phase_b=0.
  - On in_valid: A<=in_data if acc_mode=0, else A<=out_sum (in_data ignored). Then go to S_LOAD_B.
- S_LOAD_B:
  - busy=0, phase_b=1.
  - On in_valid: B<=in_data, counter<=SETTLE_CYCLES-1, go to S_WAIT.
  - No timeout; the controller waits indefinitely for B.
- S_WAIT:
  - busy=1.
  - When counter!=0: counter decrements.
  - When counter==0: out_sum<=s and out_carry<=c from the adder, out_valid<=1, go to S_IDLE.
- out_valid:
  - Registered; high for exactly the one cycle after the sampling edge. At that point the state is already S_IDLE.
  - Cleared on every other edge.
- Latency: from the B-accept edge to the edge that raises out_valid is SETTLE_CYCLES+1 edges.
- Back-to-back operation: in_valid in the out_valid cycle is accepted as a new A, so no bubble is required. With acc_mode=1 in that cycle, A takes the just-updated out_sum.
- Adder inputs:
  - a=A and b=B are driven directly from registers, so they are stable for the whole S_WAIT window.
  - A and B change only on accept edges.
- Arithmetic: {out_carry,out_sum} = A+B modulo 2^(WIDTH+1); no carry-in.
- in_valid in S_WAIT is dropped silently. No sticky error flag.
- acc_mode is sampled only on the A-phase accept and is a don't-care otherwise.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE=2'd0, S_LOAD_B=2'd1, S_WAIT=2'd2;
  - counter width, fixed at 4 bits to cover SETTLE_CYCLES≤15.
- One sub-module only: the existing carry_look_ahead, instantiated as the shared datapath. The sequencer contains no arithmetic of its own.

Test Plan (WIDTH=7, SETTLE_CYCLES=2 unless noted):
- Basic add: accept A=0x25, then B=0x1A → out_valid pulses exactly 3 edges after the B accept; out_sum=0x3F, out_carry=0.
- Overflow: A=0x7F, B=0x01 → out_sum=0x00, out_carry=1. Then A=0x7F, B=0x7F → out_sum=0x7E, out_carry=1.
- Accumulate: A=0x10, B=0x05 (sum 0x15); then acc_mode=1 with in_data=0x55 and B=0x03 → out_sum=0x18. Confirms in_data was ignored on the A phase.
- Busy drop plus back-to-back:
  - pulse in_valid with 0x33 during S_WAIT → result still A+B; state unaffected.
  - in_valid asserted in the out_valid cycle is taken as the next A.
- Reset mid-op: assert rst for 1 cycle while in S_WAIT → no out_valid; out_sum=0, busy=0, phase_b=0. The next A/B pair (0x02, 0x03) yields 0x05.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15 builds: latency measured at 2 and 16 edges respectively; busy high for exactly SETTLE_CYCLES cycles.
